// File: rtl/baud_rate_gen.sv
// baud_rate_gen: programmable oversample / bit-rate tick generator for the UART.
// A down-counter produces o_ticks every `period` clocks. Every OVERSAMPLE-th
// o_ticks also raises o_bit_tick. A divisor written through the shadow register
// only takes effect at a tick boundary, so a reload never shortens or splits a
// period that is already running.
// Optional feature: define BAUD_FRAC_DIV_EN to build the fractional
// accumulator, which adds one extra clock to a period on each accumulator carry.
// Without it, i_div_frac is accepted but ignored.
module baud_rate_gen #(
  parameter int DIV_W       = 16,
  parameter int FRAC_W      = 4,
  parameter int OVERSAMPLE  = 16,
  parameter int DEFAULT_DIV = 651
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_enable,
  input  logic              i_sync,
  input  logic [DIV_W-1:0]  i_div_int,
  input  logic [FRAC_W-1:0] i_div_frac,
  input  logic              i_div_load,
  output logic              o_pending,
  output logic              o_ticks,
  output logic              o_bit_tick
);

  localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [DIV_W-1:0] RST_DIV   = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] RST_CNT   = DIV_W'(DEFAULT_DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

  // Registered state
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  logic [DIV_W-1:0] active_int_q, active_int_d;
  logic [DIV_W-1:0] shadow_int_q, shadow_int_d;
  logic             pending_q, pending_d;
  logic             ticks_q, ticks_d;
  logic             bit_tick_q, bit_tick_d;

  // Divisor in force for this edge: the shadow wins whenever it is about to be
  // applied, because the reload on that edge must already use the new value.
  logic             apply_shadow;
  logic [DIV_W-1:0] use_int;
  logic [DIV_W-1:0] eff_int_m1;
  logic             carry;

`ifdef BAUD_FRAC_DIV_EN
  logic [FRAC_W-1:0] active_frac_q, active_frac_d;
  logic [FRAC_W-1:0] shadow_frac_q, shadow_frac_d;
  logic [FRAC_W-1:0] frac_acc_q, frac_acc_d;
  logic [FRAC_W-1:0] use_frac;
  logic [FRAC_W:0]   frac_sum;
`else
  // The fractional input stays on the port for a uniform interface.
  logic unused_div_frac;
  assign unused_div_frac = ^i_div_frac;
`endif

  // Resolve the effective divisor and the fractional carry for a reload now
  always_comb begin
    apply_shadow = pending_q & (i_sync | ~i_enable | (cnt_q == '0));
    use_int      = apply_shadow ? shadow_int_q : active_int_q;
    // A divisor of 0 behaves like 1: tick every cycle.
    eff_int_m1   = (use_int == '0) ? '0 : (use_int - DIV_ONE);
`ifdef BAUD_FRAC_DIV_EN
    use_frac     = apply_shadow ? shadow_frac_q : active_frac_q;
    frac_sum     = {1'b0, frac_acc_q} + {1'b0, use_frac};
    carry        = frac_sum[FRAC_W];
`else
    carry        = 1'b0;
`endif
  end

  // Next-state logic: sync beats boundary; disable freezes the counters
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    cnt_d        = cnt_q;
    os_cnt_d     = os_cnt_q;
    active_int_d = active_int_q;
    shadow_int_d = shadow_int_q;
    pending_d    = pending_q;
    ticks_d      = 1'b0;
    bit_tick_d   = 1'b0;
`ifdef BAUD_FRAC_DIV_EN
    active_frac_d = active_frac_q;
    shadow_frac_d = shadow_frac_q;
    frac_acc_d    = frac_acc_q;
`endif

    // Shadow promotion happens on sync, while disabled, or at a boundary.
    if (apply_shadow) begin
      active_int_d = shadow_int_q;
`ifdef BAUD_FRAC_DIV_EN
      active_frac_d = shadow_frac_q;
`endif
      pending_d    = 1'b0;
    end

    if (i_sync) begin
      cnt_d    = eff_int_m1;
      os_cnt_d = '0;
`ifdef BAUD_FRAC_DIV_EN
      frac_acc_d = '0;
`endif
    end else if (i_enable) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - DIV_ONE;
      end else begin
        ticks_d    = 1'b1;
        bit_tick_d = (os_cnt_q == OS_LAST);
        os_cnt_d   = (os_cnt_q == OS_LAST) ? '0 : (os_cnt_q + OS_W'(1));
        // period - 1 = eff_int - 1 + carry; cannot overflow DIV_W bits.
        cnt_d      = eff_int_m1 + DIV_W'(carry);
`ifdef BAUD_FRAC_DIV_EN
        frac_acc_d = frac_sum[FRAC_W-1:0];
`endif
      end
    end

    // A load lands in the shadow and stays pending for a later reload, even
    // when the current edge promoted an older shadow value.
    if (i_div_load) begin
      shadow_int_d = i_div_int;
`ifdef BAUD_FRAC_DIV_EN
      shadow_frac_d = i_div_frac;
`endif
      pending_d    = 1'b1;
    end
  end

  // State register with synchronous active-high reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      cnt_q        <= RST_CNT;
      os_cnt_q     <= '0;
      active_int_q <= RST_DIV;
      shadow_int_q <= RST_DIV;
      pending_q    <= 1'b0;
      ticks_q      <= 1'b0;
      bit_tick_q   <= 1'b0;
`ifdef BAUD_FRAC_DIV_EN
      active_frac_q <= '0;
      shadow_frac_q <= '0;
      frac_acc_q    <= '0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      os_cnt_q     <= os_cnt_d;
      active_int_q <= active_int_d;
      shadow_int_q <= shadow_int_d;
      pending_q    <= pending_d;
      ticks_q      <= ticks_d;
      bit_tick_q   <= bit_tick_d;
`ifdef BAUD_FRAC_DIV_EN
      active_frac_q <= active_frac_d;
      shadow_frac_q <= shadow_frac_d;
      frac_acc_q    <= frac_acc_d;
`endif
    end
  end

  assign o_pending  = pending_q;
  assign o_ticks    = ticks_q;
  assign o_bit_tick = bit_tick_q;

endmodule

// File: tb/tb_baud_rate_gen.sv
// Directed bench for baud_rate_gen with default parameters (DIV 651, OS 16).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_baud_rate_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_enable;
  logic        i_sync;
  logic [15:0] i_div_int;
  logic [3:0]  i_div_frac;
  logic        i_div_load;
  logic        o_pending;
  logic        o_ticks;
  logic        o_bit_tick;

  int n_checks = 0;
  int n_pass   = 0;

  baud_rate_gen dut (
    .clk        (clk),
    .reset      (reset),
    .i_enable   (i_enable),
    .i_sync     (i_sync),
    .i_div_int  (i_div_int),
    .i_div_frac (i_div_frac),
    .i_div_load (i_div_load),
    .o_pending  (o_pending),
    .o_ticks    (o_ticks),
    .o_bit_tick (o_bit_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges until o_ticks is seen (bounded by max).
  task automatic wait_tick(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!o_ticks && n < max);
  endtask

  // Edges until o_bit_tick is seen (bounded by max).
  task automatic wait_bit(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!o_bit_tick && n < max);
  endtask

  task automatic load(input int div_int, input int div_frac);
    i_div_int  = 16'(div_int);
    i_div_frac = 4'(div_frac);
    i_div_load = 1'b1;
    step();
    i_div_load = 1'b0;
  endtask

  initial begin
    int n;
    int sum;
    reset = 1'b1; i_enable = 1'b0; i_sync = 1'b0;
    i_div_int = '0; i_div_frac = '0; i_div_load = 1'b0;
    step(); step();
    check("rst_ticks", o_ticks, 0);
    check("rst_bit", o_bit_tick, 0);
    check("rst_pending", o_pending, 0);

    // First tick after DEFAULT_DIV edges.
    reset = 1'b0; i_enable = 1'b1;
    wait_tick(1000, n);
    check("first_tick", n, 651);

    // Load 4 just after a tick: pending until the next boundary.
    load(4, 0);
    check("load4_pending", o_pending, 1);
    wait_tick(1000, n);
    check("load4_boundary", n, 650);
    check("load4_pend_clr", o_pending, 0);
    wait_tick(100, n);
    check("div4_spacing", n, 4);
    // Three ticks so far; bit tick on the 16th.
    wait_bit(200, n);
    check("bit_first", n, 52);
    check("bit_coinc1", o_ticks, 1);
    wait_bit(200, n);
    check("bit_period", n, 64);
    check("bit_coinc2", o_ticks, 1);
    wait_tick(100, n);
    check("div4_after_bit", n, 4);
    check("no_bit_after", o_bit_tick, 0);

    // Load 10 mid-period: current period stays 4 cycles.
    step();
    load(10, 0);
    check("load10_pending", o_pending, 1);
    wait_tick(100, n);
    check("load10_rest", n, 2);
    check("load10_pend_clr", o_pending, 0);
    wait_tick(100, n);
    check("div10_spacing", n, 10);

    // Two loads in one period: only the last (8) is applied.
    load(6, 0);
    step();
    load(8, 0);
    wait_tick(100, n);
    check("dbl_rest", n, 7);
    wait_tick(100, n);
    check("dbl_div8_a", n, 8);
    wait_tick(100, n);
    check("dbl_div8_b", n, 8);

    // Back to 4, then sync mid-period.
    load(4, 0);
    wait_tick(100, n);
    check("reload4_rest", n, 7);
    wait_tick(100, n);
    check("reload4_spacing", n, 4);
    step();
    i_sync = 1'b1; step(); i_sync = 1'b0;
    check("sync_no_tick", o_ticks, 0);
    wait_tick(100, n);
    check("sync_first_tick", n, 4);
    wait_bit(200, n);
    check("sync_bit", n, 60);
    // Sync on the boundary edge suppresses the tick.
    step(); step(); step();
    i_sync = 1'b1; step(); i_sync = 1'b0;
    check("sync_bnd_supp", o_ticks, 0);
    wait_tick(100, n);
    check("sync_bnd_next", n, 4);

    // Enable low for 7 cycles mid-period.
    step(); step();
    i_enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      check("dis_ticks", o_ticks, 0);
    end
    check("dis_bit", o_bit_tick, 0);
    i_enable = 1'b1;
    wait_tick(100, n);
    check("dis_resume", n, 2);

    // Pending applied immediately while disabled; then divisor 1.
    load(1, 0);
    i_enable = 1'b0; step(); i_enable = 1'b1;
    check("dis_apply_pend", o_pending, 0);
    wait_tick(100, n);
    check("div1_rest", n, 3);
    for (int i = 0; i < 4; i++) begin
      step();
      check("div1_every", o_ticks, 1);
    end

    // Divisor 0 applied through sync.
    load(0, 0);
    i_sync = 1'b1; step(); i_sync = 1'b0;
    check("div0_sync_pend", o_pending, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("div0_every", o_ticks, 1);
    end

    // Fractional divisor 4 + 8/16.
    load(4, 8);
    i_sync = 1'b1; step(); i_sync = 1'b0;
    wait_tick(100, n);
    check("frac_first", n, 4);
    sum = 0;
    for (int i = 0; i < 32; i++) begin
      wait_tick(100, n);
`ifdef BAUD_FRAC_DIV_EN
      if (i < 2) check("frac_spacing", n, (i == 0) ? 4 : 5);
`else
      if (i < 2) check("frac_ignored", n, 4);
`endif
      sum += n;
    end
`ifdef BAUD_FRAC_DIV_EN
    check("frac_span32", sum, 144);
`else
    check("nofrac_span32", sum, 128);
`endif

    // Reset mid-period with a simultaneous load: load discarded.
    step();
    reset = 1'b1; i_div_int = 16'd7; i_div_load = 1'b1;
    step();
    reset = 1'b0; i_div_load = 1'b0;
    check("rst_mid_pending", o_pending, 0);
    check("rst_mid_ticks", o_ticks, 0);
    wait_tick(1000, n);
    check("rst_mid_first", n, 651);
    wait_tick(1000, n);
    check("rst_mid_div", n, 651);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
